// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle accumulator CPU control unit:
// opcode values, FSM state encoding, ALU select reset value and decode helpers.
package cu_pkg;

  localparam logic [31:0] OP_CLA  = 32'd0;
  localparam logic [31:0] OP_COM  = 32'd1;
  localparam logic [31:0] OP_SHR  = 32'd2;
  localparam logic [31:0] OP_CSL  = 32'd3;
  localparam logic [31:0] OP_STOP = 32'd4;
  localparam logic [31:0] OP_ADD  = 32'd5;
  localparam logic [31:0] OP_STA  = 32'd6;
  localparam logic [31:0] OP_LDA  = 32'd7;
  localparam logic [31:0] OP_JMP  = 32'd8;
  localparam logic [31:0] OP_BAN  = 32'd9;

  // All-ones ALU select shown while no instruction has been decoded (ALU_S_W <= 16)
  localparam logic [15:0] ALU_S_RESET = '1;

  typedef enum logic [2:0] {
    S_HALT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM
  } state_t;

  // True for the ten opcodes of the ISA
  function automatic logic op_defined(input logic [31:0] op);
    return op <= OP_BAN;
  endfunction

  // State that follows DECODE; undefined opcodes fall back to FETCH (NOP)
  function automatic state_t decode_next(input logic [31:0] op);
    case (op)
      OP_STOP:                                        return S_HALT;
      OP_ADD, OP_STA, OP_LDA:                         return S_MEM;
      OP_CLA, OP_COM, OP_SHR, OP_CSL, OP_JMP, OP_BAN: return S_EXEC;
      default:                                        return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_cu_if.sv
// Control-unit bus: IR/datapath status in, datapath strobes and ALU select out.
// master = datapath/IR side, slave = control unit.
interface multicycle_cu_if #(
  parameter int OP_W    = 4,
  parameter int ALU_S_W = 4
);
  logic               run_i;
  logic [OP_W-1:0]    op_i;
  logic               acc_neg_i;
  logic               ram_re;
  logic               ram_we;
  logic               ir_we;
  logic               pc_inc;
  logic               pc_load;
  logic               acc_we;
  logic               jmp;
  logic               ban;
  logic [ALU_S_W-1:0] alu_s;
  logic               stop;
  logic               illegal;

  modport master (
    output run_i, op_i, acc_neg_i,
    input  ram_re, ram_we, ir_we, pc_inc, pc_load, acc_we, jmp, ban, alu_s, stop, illegal
  );

  modport slave (
    input  run_i, op_i, acc_neg_i,
    output ram_re, ram_we, ir_we, pc_inc, pc_load, acc_we, jmp, ban, alu_s, stop, illegal
  );
endinterface

// File: rtl/cu_wait_ctr.sv
// Wait-state counter shared by FETCH and MEM. Counts 0..MEM_WAIT while enabled,
// restarts on clear; 'last' marks the final cycle of a RAM access.
// With MEM_WAIT=0 every access is a single cycle and no counter is built.
module cu_wait_ctr #(
  parameter int MEM_WAIT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic last
);

  if (MEM_WAIT == 0) begin : g_no_wait
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, clear, enable};
    assign last      = 1'b1;
  end else begin : g_wait
    localparam int CW = $clog2(MEM_WAIT + 1);
    logic [CW-1:0] cnt;

    // Advance during an access, restart whenever the FSM changes state
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cnt <= '0;
      else if (clear)  cnt <= '0;
      else if (enable) cnt <= cnt + CW'(1);
    end

    assign last = (cnt == CW'(MEM_WAIT));
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit for the accumulator CPU: HALT/FETCH/DECODE/EXEC/MEM.
// Strobes are decoded from state, latched opcode and wait counter so that an
// asynchronous reset clears them immediately.
// Optional feature macro: CU_ILLEGAL_TRAP_EN (undefined opcode halts and sets
// a sticky illegal flag); without it an undefined opcode is a NOP.
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int OP_W     = 4,
  parameter int ALU_S_W  = 4,
  parameter int MEM_WAIT = 0
) (
  input logic            clk,
  input logic            rst_n,
  multicycle_cu_if.slave bus
);

  state_t             state;
  logic [OP_W-1:0]    op_q;
  logic [31:0]        op_q_ext;
  logic [ALU_S_W-1:0] alu_s_q;
  logic               ctr_en;
  logic               ctr_clr;
  logic               ctr_last;

  assign op_q_ext = 32'(op_q);
  assign ctr_en   = (state == S_FETCH) || (state == S_MEM);
  assign ctr_clr  = !ctr_en || ctr_last;

  cu_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (ctr_clr),
    .enable (ctr_en),
    .last   (ctr_last)
  );

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q;
`endif

  // Instruction sequencing, opcode latch, held ALU select and sticky trap flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_HALT;
      op_q    <= '0;
      alu_s_q <= ALU_S_RESET[ALU_S_W-1:0];
`ifdef CU_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_HALT:  if (bus.run_i) state <= S_FETCH;
        S_FETCH: if (ctr_last) state <= S_DECODE;
        S_DECODE: begin
          op_q    <= bus.op_i;
          alu_s_q <= ALU_S_W'(bus.op_i);
`ifdef CU_ILLEGAL_TRAP_EN
          if (!op_defined(32'(bus.op_i))) begin
            state     <= S_HALT;
            illegal_q <= 1'b1;
          end else
`endif
          state <= decode_next(32'(bus.op_i));
        end
        S_EXEC:  state <= S_FETCH;
        S_MEM:   if (ctr_last) state <= S_FETCH;
        default: state <= S_HALT;
      endcase
    end
  end

  // Strobe decode; ram_re spans the whole access, the rest fire on one cycle
  always_comb begin
    bus.ram_re  = 1'b0;
    bus.ram_we  = 1'b0;
    bus.ir_we   = 1'b0;
    bus.pc_inc  = 1'b0;
    bus.pc_load = 1'b0;
    bus.acc_we  = 1'b0;
    bus.jmp     = 1'b0;
    bus.ban     = 1'b0;
    case (state)
      S_FETCH: begin
        bus.ram_re = 1'b1;
        bus.ir_we  = ctr_last;
        bus.pc_inc = ctr_last;
      end
      S_EXEC: begin
        case (op_q_ext)
          OP_CLA, OP_COM, OP_SHR, OP_CSL: bus.acc_we = 1'b1;
          OP_JMP: begin
            bus.jmp     = 1'b1;
            bus.pc_load = 1'b1;
          end
          OP_BAN: begin
            bus.ban     = 1'b1;
            bus.pc_load = bus.acc_neg_i;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        case (op_q_ext)
          OP_ADD, OP_LDA: begin
            bus.ram_re = 1'b1;
            bus.acc_we = ctr_last;
          end
          OP_STA:  bus.ram_we = ctr_last;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.alu_s = alu_s_q;
  assign bus.stop  = (state == S_HALT);

`ifdef CU_ILLEGAL_TRAP_EN
  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

endmodule
